// File: rtl/seq_arrdiv.sv
// seq_arrdiv: sequential restoring divider evaluating UNROLL array rows per clock with valid/ready handshakes
module seq_arrdiv #(
  parameter int N = 8,
  parameter int UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int STEPS = N / UNROLL;
  localparam int CW = $clog2(STEPS) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [N-1:0] dvd, dvs, quo, nd, nq;
  logic [N:0] rem, nr;
  logic [CW-1:0] cnt;
  if (N < 2 || N > 64 || N % UNROLL != 0) begin : g_bad_param
    $error("seq_arrdiv: N must be 2..64 and divisible by UNROLL");
  end
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    logic [N:0] rs;
    logic [N+1:0] diff;
    nr = rem;
    nd = dvd;
    nq = quo;
    rs = '0;
    diff = '0;
    for (int i = 0; i < UNROLL; i++) begin
      rs = {nr[N-1:0], nd[N-1]};
      diff = {1'b0, rs} - {2'b0, dvs};
      nr = diff[N+1] ? rs : diff[N:0];
      nq = {nq[N-2:0], ~diff[N+1]};
      nd = {nd[N-2:0], 1'b0};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      quotient <= '0;
      remainder <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvd <= a;
          dvs <= b;
          rem <= '0;
          quo <= '0;
          cnt <= '0;
          state <= BUSY;
        end
        BUSY: begin
          rem <= nr;
          dvd <= nd;
          quo <= nq;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(STEPS - 1)) begin
            quotient <= nq;
            remainder <= nr[N-1:0];
            div_by_zero <= dvs == '0;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_arrdiv.sv
// tb_seq_arrdiv: randomized self-checking bench for seq_arrdiv against an arithmetic reference
module tb_seq_arrdiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv = 1'b0;
  logic ir;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic ov;
  logic ordy = 1'b0;
  logic [7:0] q, r;
  logic dz;
  int n_chk = 0;
  int n_fail = 0;
  logic [2:0] sw_done = '0;

  always #5 clk = ~clk;

  seq_arrdiv #(.N(8), .UNROLL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .a(a), .b(b),
    .out_valid(ov), .out_ready(ordy), .quotient(q), .remainder(r), .div_by_zero(dz)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] ta, input logic [7:0] tb);
    for (int i = 0; i < 50 && !ir; i++) tick();
    check("accept_ready", ir, 1);
    iv = 1'b1;
    a = ta;
    b = tb;
    tick();
    iv = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
  endtask

  task automatic op(input logic [7:0] ta, input logic [7:0] tb, input int hold);
    int lat;
    logic [7:0] eq, er;
    eq = (tb == 0) ? 8'hFF : ta / tb;
    er = (tb == 0) ? ta : ta % tb;
    accept(ta, tb);
    lat = 0;
    while (!ov && lat < 30) begin
      check("busy_in_ready", ir, 0);
      tick();
      lat++;
    end
    check("latency", lat, 8);
    check("quotient", q, eq);
    check("remainder", r, er);
    check("div_by_zero", dz, tb == 0);
    for (int i = 0; i < hold; i++) begin
      iv = 1'($urandom);
      a = 8'($urandom);
      b = 8'($urandom);
      tick();
      check("hold_valid", ov, 1);
      check("hold_in_ready", ir, 0);
      check("hold_quotient", q, eq);
      check("hold_remainder", r, er);
    end
    iv = 1'b0;
    ordy = 1'b1;
    tick();
    ordy = 1'b0;
    check("release_valid", ov, 0);
    check("release_in_ready", ir, 1);
  endtask

  initial begin
    tick();
    rst = 1'b0;
    check("rst_in_ready", ir, 1);
    check("rst_out_valid", ov, 0);
    check("rst_quotient", q, 0);
    check("rst_remainder", r, 0);
    check("rst_dbz", dz, 0);
    op(200, 7, 0);
    op(8'h5A, 0, 0);
    op(9, 3, 0);
    op(3, 9, 0);
    op(255, 1, 0);
    op(100, 9, 5);
    accept(77, 5);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", ir, 1);
    check("midrst_out_valid", ov, 0);
    check("midrst_quotient", q, 0);
    check("midrst_remainder", r, 0);
    check("midrst_dbz", dz, 0);
    op(50, 6, 0);
    for (int i = 0; i < 30; i++) op(8'($urandom), 8'($urandom_range(0, 20)), int'($urandom_range(0, 2)));
    for (int i = 0; i < 30000 && sw_done != 3'b111; i++) @(posedge clk);
    check("sweep_done", sw_done, 3'b111);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int U = 1 << g;
    logic srst = 1'b1;
    logic siv = 1'b0;
    logic sir, sov, sdz;
    logic sordy = 1'b0;
    logic [3:0] sa = '0;
    logic [3:0] sb = '0;
    logic [3:0] sq, sr;

    seq_arrdiv #(.N(4), .UNROLL(U)) dut4 (
      .clk(clk), .rst(srst), .in_valid(siv), .in_ready(sir), .a(sa), .b(sb),
      .out_valid(sov), .out_ready(sordy), .quotient(sq), .remainder(sr), .div_by_zero(sdz)
    );

    initial begin
      int lat;
      @(posedge clk);
      #1;
      srst = 1'b0;
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          for (int i = 0; i < 20 && !sir; i++) begin
            @(posedge clk);
            #1;
          end
          siv = 1'b1;
          sa = 4'(x);
          sb = 4'(y);
          @(posedge clk);
          #1;
          siv = 1'b0;
          lat = 0;
          while (!sov && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
          end
          check("sweep_latency", lat, 4 / U);
          check("sweep_quotient", sq, (y == 0) ? 15 : x / y);
          check("sweep_remainder", sr, (y == 0) ? x : x % y);
          check("sweep_dbz", sdz, y == 0);
          for (int i = 0; i < 20 && sov; i++) begin
            sordy = 1'($urandom);
            @(posedge clk);
            #1;
          end
          sordy = 1'b0;
          check("sweep_release", sov, 0);
        end
      end
      sw_done[g] = 1'b1;
    end
  end
endmodule

// File: doc/seq_arrdiv.md
# seq_arrdiv

Sequential, parametrised restoring divider for unsigned N-bit operands. It evaluates UNROLL rows of the restoring subtract-and-select array per clock. Operands enter and quotient/remainder leave through valid/ready handshakes. It sits in the arithmetic library as the pipelined-datapath alternative to the purely combinational array dividers, trading latency for area, and it also returns the remainder and a divide-by-zero flag.

## Interface
- N, default 8: operand, quotient and remainder width; legal range 2..64.
- UNROLL, default 1: array rows evaluated per cycle; must divide N (elaboration error otherwise).
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a, b are presented.
- in_ready  output  1  divider can accept operands.
- a  input  N  dividend.
- b  input  N  divisor.
- out_valid  output  1  result registers hold a completed result.
- out_ready  input  1  consumer accepts the result.
- quotient  output  N  floor(a/b); all ones when b==0.
- remainder  output  N  a mod b; equals a when b==0.
- div_by_zero  output  1  set with the result when the captured b was 0.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE: on in_valid && in_ready:
  - capture a into the dividend shift register and b into the divisor register;
  - clear the partial remainder (N+1 bits) and the quotient register;
  - clear the step counter;
  - go to BUSY.
- BUSY: each cycle applies UNROLL rows, MSB first. Per row:
  - shift the next dividend bit into the LSB of the partial remainder: R' = {R[N-1:0], a_bit};
  - form trial T = R' − {1'b0, b} in N+1 bits;
  - if there is no borrow, R = T and the quotient bit is 1;
  - otherwise R = R' (restore) and the quotient bit is 0;
  - shift the quotient bit into the quotient register LSB.
- The step counter (width clog2(N/UNROLL)+1) increments once per BUSY cycle. After N/UNROLL BUSY cycles:
  - load quotient and remainder (R[N-1:0]) into the output registers;
  - set div_by_zero = (captured b == 0);
  - go to DONE.
- b == 0 is not special-cased in the datapath: every trial succeeds, so quotient = 2^N−1 and remainder = a. Only the flag is added.
- DONE: outputs are held stable while out_valid && !out_ready. On out_ready, go to IDLE. The output registers keep their values until the next completion.
- Input changes while not in IDLE are ignored. Operands are sampled only on the accepting edge.
- rst (any state, including mid-BUSY): next state IDLE, any in-flight operation is discarded, and all output registers are cleared.

## Timing
- Reset values after the rst edge: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
- Latency: operands accepted on edge k; out_valid=1 from edge k+N/UNROLL.
  - N=8, UNROLL=1 gives 8 cycles.
  - N=8, UNROLL=4 gives 2 cycles.
- out_valid and the result are registered outputs; there is no combinational path from in_valid or out_ready to the outputs.
- in_ready and out_valid depend on state only; they are never combinational from inputs.
- Output handshake on edge m: in_ready=1 from edge m. The earliest next accept is edge m+1.
  - Minimum initiation interval: N/UNROLL + 2 cycles when out_ready is held high.
- rst asserted on the same edge as an input or output handshake: reset wins and the handshake is void.
- Critical path: UNROLL chained (N+1)-bit subtract/select rows.

## Test plan
- N=8, UNROLL=1, a=200, b=7, out_ready=1 -> quotient=28, remainder=4, div_by_zero=0; out_valid rises exactly 8 cycles after accept; in_ready low during those 8 cycles.
- N=8, a=0x5A, b=0 -> quotient=0xFF, remainder=0x5A, div_by_zero=1. Then a=9, b=3 -> div_by_zero=0, quotient=3, remainder=0.
- N=8, a=3, b=9 -> quotient=0, remainder=3. Also a=255, b=1 -> quotient=255, remainder=0.
- Backpressure: complete 100/9, hold out_ready=0 for 5 cycles while toggling a/b/in_valid -> outputs stay 11/1, in_ready stays 0. out_ready=1 -> out_valid drops the next cycle and in_ready rises.
- Reset mid-operation: accept 77/5, assert rst at BUSY cycle 3 -> all outputs 0 and in_ready=1 after the edge. A new 50/6 then returns 8/2 with full latency.
- Parameter sweep: N=4 with UNROLL in {1,2,4}, all 256 (a,b) pairs, random out_ready -> match golden a/b and a%b (b==0 convention above); latency is 4, 2 and 1 cycles respectively.
